// File: rtl/lsri_multicycle_datapath.sv
// Multi-cycle load/store/R/I datapath with valid/ready intake and req/ack data memory.
// Optional LSRI_MEM_TIMEOUT_EN bounds the memory wait and raises a sticky err.
module lsri_multicycle_datapath #(
  parameter int N           = 64,
  parameter int NREGS       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [31:0]  instruction,
  input  logic [3:0]   ALU_OP,
  input  logic         RegWrite,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic         MemToReg,
  input  logic         ALUSrc,
  input  logic         RegDst,
  input  logic         reg1,
  input  logic         reg2,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ack,
  output logic [N-1:0] immediate,
  output logic         zero_flag,
  output logic         done,
  output logic         err,
  input  logic [4:0]   dbg_raddr,
  output logic [N-1:0] dbg_rdata
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

  state_t      r_state;
  logic [31:0] r_instr;
  logic [3:0]  r_aluop;
  logic        r_regwrite, r_memrd, r_memwr, r_memtoreg;
  logic        r_alusrc, r_regdst, r_reg1, r_reg2;
  logic        r_ready, r_req, r_we, r_zero, r_done, r_wsup;
  logic [N-1:0] r_addr, r_wdata, r_result, r_ldata;
  logic [N-1:0] r_rf [NREGS];

  logic [AW-1:0] w_wr, w_rs1, w_rs2;
  logic [N-1:0]  w_imm, w_opa, w_opb, w_rs2v, w_alu;
  logic          w_mem, w_slt, w_tmo;
  logic          w_unused;

  assign w_wr  = r_regdst ? r_instr[21 +: AW] : r_instr[16 +: AW];
  assign w_rs1 = r_reg1   ? r_instr[16 +: AW] : r_instr[21 +: AW];
  assign w_rs2 = r_reg2   ? r_instr[11 +: AW] : r_instr[21 +: AW];
  assign w_mem = r_memrd | r_memwr;

  // Memory ops use the DS field unshifted; the low two bits are the XO.
  assign w_imm = w_mem ? {{(N-14){r_instr[15]}}, r_instr[15:2]}
                       : {{(N-16){r_instr[15]}}, r_instr[15:0]};

  assign w_opa  = r_rf[w_rs1];
  assign w_rs2v = r_rf[w_rs2];
  assign w_opb  = r_alusrc ? w_imm : w_rs2v;
  assign w_slt  = $signed(w_opa) < $signed(w_opb);

  always_comb begin
    w_alu = '0;
    case (r_aluop)
      4'b0000: w_alu = w_opa & w_opb;
      4'b0001: w_alu = w_opa | w_opb;
      4'b0010: w_alu = w_opa + w_opb;
      4'b0110: w_alu = w_opa - w_opb;
      4'b0111: w_alu = {{(N-1){1'b0}}, w_slt};
      4'b1100: w_alu = ~(w_opa | w_opb);
      default: w_alu = '0;
    endcase
  end

`ifdef LSRI_MEM_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign w_tmo = (r_state == MEM) && !mem_ack
              && (r_cnt == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == MEM && !mem_ack) ? r_cnt + 1'b1 : '0;
      if (w_tmo)
        r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_tmo = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_instr    <= '0;
      r_aluop    <= '0;
      r_regwrite <= 1'b0;
      r_memrd    <= 1'b0;
      r_memwr    <= 1'b0;
      r_memtoreg <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regdst   <= 1'b0;
      r_reg1     <= 1'b0;
      r_reg2     <= 1'b0;
      r_ready    <= 1'b1;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_zero     <= 1'b0;
      r_done     <= 1'b0;
      r_wsup     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_result   <= '0;
      r_ldata    <= '0;
      for (int i = 0; i < NREGS; i++)
        r_rf[i] <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: if (instr_valid) begin
          r_instr    <= instruction;
          r_aluop    <= ALU_OP;
          r_regwrite <= RegWrite;
          r_memrd    <= MemRead;
          r_memwr    <= MemWrite;
          r_memtoreg <= MemToReg;
          r_alusrc   <= ALUSrc;
          r_regdst   <= RegDst;
          r_reg1     <= reg1;
          r_reg2     <= reg2;
          r_wsup     <= 1'b0;
          r_ready    <= 1'b0;
          r_state    <= EXEC;
        end
        EXEC: begin
          r_result <= w_alu;
          r_zero   <= (w_alu == '0);
          if (w_mem) begin
            r_req   <= 1'b1;
            r_we    <= r_memwr;
            r_addr  <= w_alu;
            r_wdata <= w_rs2v;
            r_state <= MEM;
          end else begin
            r_done  <= 1'b1;
            r_state <= WB;
          end
        end
        MEM: if (mem_ack || w_tmo) begin
          if (mem_ack)
            r_ldata <= mem_rdata;
          r_wsup  <= !mem_ack;
          r_req   <= 1'b0;
          r_done  <= 1'b1;
          r_state <= WB;
        end
        WB: begin
          if (r_regwrite && !r_wsup)
            r_rf[w_wr] <= r_memtoreg ? r_ldata : r_result;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign mem_req     = r_req;
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign immediate   = w_imm;
  assign zero_flag   = r_zero;
  assign done        = r_done;
  assign dbg_rdata   = r_rf[dbg_raddr[AW-1:0]];
  assign w_unused    = ^{r_instr, dbg_raddr};

endmodule

// File: tb/tb_lsri_multicycle_datapath.sv
// Bench for lsri_multicycle_datapath: directed program plus random instructions
// checked against an arithmetic register/memory reference model.
module tb_lsri_multicycle_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [3:0]  ALU_OP;
  logic        RegWrite, MemRead, MemWrite, MemToReg;
  logic        ALUSrc, RegDst, reg1, reg2;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata, immediate, dbg_rdata;
  logic        zero_flag, done, err;
  logic [4:0]  dbg_raddr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] m_rf [32];
  logic [63:0] m_ld;

  lsri_multicycle_datapath #(.N(64), .NREGS(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .ALU_OP(ALU_OP),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .reg1(reg1), .reg2(reg2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .immediate(immediate), .zero_flag(zero_flag), .done(done),
    .err(err), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] alu_ref(input logic [3:0] op,
                                          input logic [63:0] a, b);
    longint sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return (sa < sb) ? 64'd1 : 64'd0;
      4'd12:   return ~(a | b);
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++)
      m_rf[i] = '0;
    m_ld = '0;
  endtask

  task automatic scramble();
    instruction = $urandom;
    ALU_OP      = 4'($urandom);
    {RegWrite, MemRead, MemWrite, MemToReg} = 4'($urandom);
    {ALUSrc, RegDst, reg1, reg2}            = 4'($urandom);
  endtask

  task automatic check_rf(input int r);
    dbg_raddr = 5'(r);
    #1;
    chk($sformatf("R%0d", r), dbg_rdata, m_rf[r]);
  endtask

  // wt = extra cycles memory holds off before ack
  task automatic run(input logic [31:0] ins, input logic [3:0] op,
                     input logic rw, mr, mw, m2r, asrc, rdst, r1, r2,
                     input int wt, input logic [63:0] rd);
    int rs1, rs2, wr, c, nreq, exp_c;
    bit mem;
    longint s;
    logic [63:0] imm, b, res, wd;
    wr  = rdst ? int'(ins[25:21]) : int'(ins[20:16]);
    rs1 = r1   ? int'(ins[20:16]) : int'(ins[25:21]);
    rs2 = r2   ? int'(ins[15:11]) : int'(ins[25:21]);
    mem = mr | mw;
    s   = longint'($signed(ins[15:0]));
    imm = mem ? (s >>> 2) : s;
    b   = asrc ? imm : m_rf[rs2];
    res = alu_ref(op, m_rf[rs1], b);
    wd  = m_rf[rs2];
    @(negedge clk);
    chk("ready", {63'd0, instr_ready}, 64'd1);
    instruction = ins;
    ALU_OP      = op;
    {RegWrite, MemRead, MemWrite, MemToReg} = {rw, mr, mw, m2r};
    {ALUSrc, RegDst, reg1, reg2}            = {asrc, rdst, r1, r2};
    instr_valid = 1'b1;
    @(negedge clk);
    c = 1;
    chk("imm", immediate, imm);
    scramble();
    instr_valid = 1'b0;
    mem_ack     = 1'($urandom);
    mem_rdata   = {$urandom, $urandom};
    nreq = 0;
    while (done !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
      if (mem_req === 1'b1) begin
        nreq++;
        if (nreq == 1) begin
          chk("addr", mem_addr, res);
          chk("we", {63'd0, mem_we}, {63'd0, mw});
          chk("wdata", mem_wdata, wd);
        end
        mem_ack   = (nreq == wt + 1);
        mem_rdata = mem_ack ? rd : {$urandom, $urandom};
      end else begin
        mem_ack = 1'b0;
      end
    end
    mem_ack = 1'b0;
    exp_c = mem ? 3 + wt : 2;
    chk("done_cycle", 64'(c), 64'(exp_c));
    chk("zero", {63'd0, zero_flag}, {63'd0, res == 64'd0});
    chk("req_low", {63'd0, mem_req}, 64'd0);
    if (mem) begin
      chk("req_cycles", 64'(nreq), 64'(wt + 1));
      m_ld = rd;
    end
    if (rw)
      m_rf[wr] = m2r ? m_ld : res;
    @(negedge clk);
    chk("done_pulse", {63'd0, done}, 64'd0);
    check_rf(wr);
    check_rf(int'($urandom_range(0, 31)));
  endtask

  initial begin
    int c;
    logic [31:0] ins;
    logic [3:0]  op;
    logic [3:0]  ops [8];
    logic        mr, mw;
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};
    rst = 1'b1;
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    dbg_raddr = '0;
    scramble();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {63'd0, instr_ready}, 64'd1);
    chk("rst_req", {63'd0, mem_req}, 64'd0);
    chk("rst_we", {63'd0, mem_we}, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_imm", immediate, 64'd0);
    chk("rst_zero", {63'd0, zero_flag}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);

    // addi R17,R0,20 / addi R20,R0,-1 / add R16,R17,R20
    run(32'h3A200014, 4'd2, 1,0,0,0, 1,1,1,0, 0, 0);
    run({6'd14, 5'd20, 5'd0, 16'hFFFF}, 4'd2, 1,0,0,0, 1,1,1,0, 0, 0);
    run({6'd31, 5'd16, 5'd17, 5'd20, 11'd0}, 4'd2, 1,0,0,0, 0,1,1,1, 0, 0);
    chk("R16_eq_19", m_rf[16], 64'd19);
    // ld R1,8(R17), three wait cycles
    run({6'd58, 5'd1, 5'd17, 16'd8}, 4'd2, 1,1,0,1, 1,1,1,0, 3, 64'd8);
    // std R17,8(R20)
    run({6'd62, 5'd17, 5'd20, 16'd8}, 4'd2, 0,0,1,0, 1,0,1,0, 1, 64'd0);
    // SUB to zero exercises zero_flag=1
    run({6'd31, 5'd9, 5'd17, 5'd17, 11'd0}, 4'd6, 1,0,0,0, 0,1,1,1, 0, 0);

    // reset in the middle of a load
    @(negedge clk);
    instruction = {6'd58, 5'd3, 5'd17, 16'd8};
    ALU_OP = 4'd2;
    {RegWrite, MemRead, MemWrite, MemToReg} = 4'b1101;
    {ALUSrc, RegDst, reg1, reg2}            = 4'b1110;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mid_req", {63'd0, mem_req}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_mid_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mid_ready", {63'd0, instr_ready}, 64'd1);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    mem_ack = 1'b1;
    mem_rdata = 64'hDEAD;
    @(negedge clk);
    mem_ack = 1'b0;
    check_rf(3);
    check_rf(17);

`ifdef LSRI_MEM_TIMEOUT_EN
    m_rf[17] = 64'd20;
    run(32'h3A200014, 4'd2, 1,0,0,0, 1,1,1,0, 0, 0);
    @(negedge clk);
    instruction = {6'd58, 5'd4, 5'd17, 16'd8};
    {RegWrite, MemRead, MemWrite, MemToReg} = 4'b1101;
    {ALUSrc, RegDst, reg1, reg2}            = 4'b1110;
    ALU_OP = 4'd2;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    c = 1;
    while (done !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("tmo_done_cycle", 64'(c), 64'd6);
    chk("tmo_err", {63'd0, err}, 64'd1);
    chk("tmo_req", {63'd0, mem_req}, 64'd0);
    @(negedge clk);
    check_rf(4);
    chk("tmo_err_sticky", {63'd0, err}, 64'd1);
`endif

    for (int k = 0; k < 40; k++) begin
      ins = $urandom;
      op  = ops[$urandom_range(0, 7)];
      mr  = ($urandom_range(0, 3) == 0);
      mw  = ($urandom_range(0, 3) == 0);
      run(ins, op, 1'($urandom), mr, mw, mr & 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          int'($urandom_range(0, 3)), {$urandom, $urandom});
    end

`ifndef LSRI_MEM_TIMEOUT_EN
    chk("err_tied", {63'd0, err}, 64'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsri_multicycle_datapath.md
Name: lsri_multicycle_datapath

Overview:
- Multi-cycle successor to the single-cycle load/store/R/I datapath in the uPOWER core.
- Width and register count are parametrised.
- A per-instruction valid/ready handshake replaces the implicit one-instruction-per-clock flow.
- Data memory sits behind a req/ack port with variable latency, so the block stalls on slow memory.
- Sits between Control_Unit (decoded control inputs) and an external data memory.

Parameters:
- N, 64, datapath, register and memory-data width.
- NREGS, 32, register count; power of two, 2..32. Register index = low log2(NREGS) bits of the 5-bit instruction field.
- MEM_TIMEOUT, 16, max cycles waiting for mem_ack; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  instruction and control inputs valid
- instr_ready  out  1  block can accept an instruction
- instruction  in  32  uPOWER instruction word
- ALU_OP  in  4  ALU operation from Control_Unit
- RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, reg1, reg2  in  1 each  control signals, same meaning as the current datapath
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  N  byte address (ALU result)
- mem_wdata  out  N  store data
- mem_rdata  in  N  load data, valid with mem_ack
- mem_ack  in  1  memory completes request
- immediate  out  N  extended immediate of latched instruction
- zero_flag  out  1  ALU result == 0, registered
- done  out  1  one-cycle pulse at writeback
- err  out  1  sticky memory timeout flag
- dbg_raddr  in  5  debug register read index
- dbg_rdata  out  N  combinational register file read at dbg_raddr

Behaviour:
- States: IDLE, EXEC, MEM, WB. Reset → IDLE.
- Reset clears all registers to 0. Reset values: instr_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, immediate=0, zero_flag=0, done=0, err=0.
- Accept only when instr_valid & instr_ready. instr_ready=1 only in IDLE.
- On accept, latch instruction and all control inputs; IDLE→EXEC. Inputs changing after accept have no effect.
- Field muxes:
  - write reg = RegDst ? [25:21] : [20:16]
  - rs1 = reg1 ? [20:16] : [25:21]
  - rs2 = reg2 ? [15:11] : [25:21]
- Immediate, computed from the latched word:
  - MemRead|MemWrite = 0: sign-extend [15:0] to N.
  - Otherwise: sign-extend [15:2] (DS field, unshifted) to N.
- EXEC (1 cycle):
  - Operand B = ALUSrc ? immediate : R[rs2].
  - Result and zero_flag registered at end of EXEC.
  - Next state: MEM if MemRead|MemWrite, else WB.
- ALU_OP encoding, all modulo 2^N, carries discarded: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR; any other code gives result 0.
- MEM:
  - mem_req=1; mem_we=MemWrite; mem_addr=result; mem_wdata=R[rs2].
  - All four held stable until the cycle mem_ack=1 is sampled.
  - On ack, load data is captured; next WB; mem_req=0 from the following cycle.
  - If MemRead and MemWrite are both set, the request is treated as a write.
- WB (1 cycle):
  - done=1.
  - If RegWrite, register[write reg] ← MemToReg ? captured load data : result, at end of WB.
  - Next IDLE.
- Latency, accept cycle = 0:
  - ALU instruction: done in cycle 2.
  - Memory instruction: done at cycle 3 + ack wait cycles.
  - Next accept is possible in the cycle after done.
- dbg_rdata shows the new value the cycle after the WB edge.
- mem_ack outside MEM is ignored.
- rst in any state returns to IDLE next cycle: mem_req drops, no register write, no done.

Optional Feature:
- Macro: LSRI_MEM_TIMEOUT_EN.
- When defined: a counter runs in MEM. If mem_ack is not seen within MEM_TIMEOUT cycles:
  - drop mem_req;
  - set err (sticky until rst);
  - go to WB with the register write suppressed; done still pulses.
- When undefined: MEM waits indefinitely and err is tied to 0.

Test Plan:
- Reset, then instr_valid with addi R17,R0,20 (0x3A200014, ALUSrc=1, RegWrite=1, ALU_OP=0010) → done in cycle 2; dbg R17=20; zero_flag=0.
- Then addi R20,R0,-1 (imm 0xFFFF) → R20=0xFFFF_FFFF_FFFF_FFFF. Then add R16,R17,R20 with ALUSrc=0 → R16=19.
- ld R1,8(R17) with DS imm=2, memory acking after 3 wait cycles with rdata=8 → mem_addr=22, mem_we=0; mem_req held 4 cycles; R1=8; done at cycle 6.
- std R17 to 2(R20) with MemWrite=1 → mem_we=1, mem_wdata=20, mem_addr=1; no register changes.
- Assert rst during MEM of a load → mem_req=0 next cycle; target register stays 0; instr_ready=1.
- With LSRI_MEM_TIMEOUT_EN and MEM_TIMEOUT=4, mem_ack never asserted → err=1 after 4 MEM cycles; done pulses; no register write.
